// File: rtl/gate_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and evaluation.
package gate_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned EVAL_W = 64;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NAND  = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSA = 3'd7
   } gate_op_e;

   // Evaluated at full width; callers keep the low W bits of the result.
   function automatic logic [EVAL_W-1:0] gate_eval(input gate_op_e op,
                                                   input logic [EVAL_W-1:0] a,
                                                   input logic [EVAL_W-1:0] b);
      logic [EVAL_W-1:0] r;
      r = a;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_NAND:  r = ~(a & b);
         OP_NOR:   r = ~(a | b);
         OP_XOR:   r = a ^ b;
         OP_XNOR:  r = ~(a ^ b);
         OP_NOTA:  r = ~a;
         OP_PASSA: r = a;
         default:  r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// Generic valid/ready register slice; accepts a beat whenever empty or drained downstream.
module gate_pipe_stage #(
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [PW-1:0] i_data,
   output logic          o_valid,
   output logic [PW-1:0] o_data,
   input  logic          i_ready
);

   logic          r_valid;
   logic [PW-1:0] r_data;
   logic          w_adv;

   assign w_adv   = !r_valid || i_ready;
   assign o_ready = w_adv;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_adv) begin
         r_valid <= i_valid;
         if (i_valid) r_data <= i_data;
      end
   end

endmodule

// File: rtl/gate_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with per-result popcount.
// Optional transfer/stall counters are built when GATE_UNIT_STATS_EN is defined.
module gate_unit_pipe
   import gate_pkg::*;
#(
   parameter  int unsigned W  = 8,
   localparam int unsigned CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    op,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y,
   output logic [2:0]    y_op,
   output logic [CW-1:0] y_ones
`ifdef GATE_UNIT_STATS_EN
   ,
   output logic [31:0]   beat_cnt,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int unsigned S1_W = OP_W + 2 * W;
   localparam int unsigned S2_W = CW + OP_W + W;

   logic            w_s1_v;
   logic            w_s2_ready;
   logic [S1_W-1:0] w_s1_in;
   logic [S1_W-1:0] w_s1_data;
   logic [S2_W-1:0] w_s2_in;
   logic [S2_W-1:0] w_s2_data;
   gate_op_e        w_op;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [W-1:0]    w_y;
   logic [CW-1:0]   w_ones;

   assign w_s1_in = {op, a, b};

   gate_pipe_stage #(.PW(S1_W)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_s1_in),
      .o_valid (w_s1_v),
      .o_data  (w_s1_data),
      .i_ready (w_s2_ready)
   );

   assign w_op = gate_op_e'(w_s1_data[S1_W-1 -: OP_W]);
   assign w_a  = w_s1_data[2*W-1:W];
   assign w_b  = w_s1_data[W-1:0];
   assign w_y  = W'(gate_eval(w_op, EVAL_W'(w_a), EVAL_W'(w_b)));

   always_comb begin
      w_ones = '0;
      for (int unsigned i = 0; i < W; i++) w_ones = w_ones + CW'(w_y[i]);
   end

   assign w_s2_in = {w_ones, w_op, w_y};

   gate_pipe_stage #(.PW(S2_W)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_s1_v),
      .o_ready (w_s2_ready),
      .i_data  (w_s2_in),
      .o_valid (out_valid),
      .o_data  (w_s2_data),
      .i_ready (out_ready)
   );

   assign {y_ones, y_op, y} = w_s2_data;

`ifdef GATE_UNIT_STATS_EN
   logic [31:0] r_beat_cnt;
   logic [31:0] r_stall_cnt;

   // beat count wraps, stall count saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready) r_beat_cnt <= r_beat_cnt + 32'd1;
         if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign beat_cnt  = r_beat_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Self-checking bench: W=1, 8 and 64 instances run in lockstep against a queue-based reference model.
module tb_gate_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  op;
   logic [63:0] a;
   logic [63:0] b;

   logic        ir1, ir8, ir64;
   logic        ov1, ov8, ov64;
   logic [0:0]  y1;
   logic [7:0]  y8;
   logic [63:0] y64;
   logic [2:0]  yop1, yop8, yop64;
   logic [0:0]  yo1;
   logic [3:0]  yo8;
   logic [6:0]  yo64;
`ifdef GATE_UNIT_STATS_EN
   logic [31:0] bc1, sc1, bc8, sc8, bc64, sc64;
`endif

   always #5 clk = ~clk;

   gate_unit_pipe #(.W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .op(op),
      .a(a[0:0]), .b(b[0:0]), .out_valid(ov1), .out_ready(out_ready),
      .y(y1), .y_op(yop1), .y_ones(yo1)
`ifdef GATE_UNIT_STATS_EN
      , .beat_cnt(bc1), .stall_cnt(sc1)
`endif
   );

   gate_unit_pipe #(.W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .op(op),
      .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
      .y(y8), .y_op(yop8), .y_ones(yo8)
`ifdef GATE_UNIT_STATS_EN
      , .beat_cnt(bc8), .stall_cnt(sc8)
`endif
   );

   gate_unit_pipe #(.W(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .op(op),
      .a(a), .b(b), .out_valid(ov64), .out_ready(out_ready),
      .y(y64), .y_op(yop64), .y_ones(yo64)
`ifdef GATE_UNIT_STATS_EN
      , .beat_cnt(bc64), .stall_cnt(sc64)
`endif
   );

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      int          age;
   } beat_t;

   beat_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_beats  = 0;
   int    exp_stalls = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_f(input logic [2:0] o, input logic [63:0] x, input logic [63:0] z);
      case (o)
         3'd0: return x & z;
         3'd1: return x | z;
         3'd2: return ~(x & z);
         3'd3: return ~(x | z);
         3'd4: return x ^ z;
         3'd5: return ~(x ^ z);
         3'd6: return ~x;
         default: return x;
      endcase
   endfunction

   // A beat is visible two edges after acceptance, and only once everything older has left.
   task automatic cycle(input logic iv, input logic [2:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input logic ordy);
      logic        exp_ov, exp_ir;
      logic [63:0] r;
      beat_t       nb;
      @(negedge clk);
      in_valid = iv; op = o; a = av; b = bv; out_ready = ordy;
      #1;
      exp_ov = (q.size() > 0) && (q[0].age >= 2);
      exp_ir = (q.size() < 2) || ordy;
      check_eq("out_valid_w1", 64'(ov1), 64'(exp_ov));
      check_eq("out_valid_w8", 64'(ov8), 64'(exp_ov));
      check_eq("out_valid_w64", 64'(ov64), 64'(exp_ov));
      check_eq("in_ready_w1", 64'(ir1), 64'(exp_ir));
      check_eq("in_ready_w8", 64'(ir8), 64'(exp_ir));
      check_eq("in_ready_w64", 64'(ir64), 64'(exp_ir));
      if (exp_ov) begin
         r = ref_f(q[0].op, q[0].a, q[0].b);
         check_eq("y_w1", 64'(y1), 64'(r[0]));
         check_eq("y_w8", 64'(y8), 64'(r[7:0]));
         check_eq("y_w64", y64, r);
         check_eq("ones_w1", 64'(yo1), 64'(r[0]));
         check_eq("ones_w8", 64'(yo8), 64'($countones(r[7:0])));
         check_eq("ones_w64", 64'(yo64), 64'($countones(r)));
         check_eq("y_op_w8", 64'(yop8), 64'(q[0].op));
         check_eq("y_op_w64", 64'(yop64), 64'(q[0].op));
         if (ordy) begin
            void'(q.pop_front());
            exp_beats++;
         end else begin
            exp_stalls++;
         end
      end
      if (iv && exp_ir) begin
         nb.op = o; nb.a = av; nb.b = bv; nb.age = 0;
         q.push_back(nb);
      end
      for (int i = 0; i < q.size(); i++) q[i].age++;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_out_valid", 64'({ov1, ov8, ov64}), 64'd0);
      check_eq("rst_y_w8", 64'(y8), 64'd0);
      check_eq("rst_y_w64", y64, 64'd0);
      check_eq("rst_ones_w64", 64'(yo64), 64'd0);
      check_eq("rst_in_ready", 64'({ir1, ir8, ir64}), 64'h7);
      q.delete();
      exp_beats  = 0;
      exp_stalls = 0;
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
   endtask

   initial begin
      logic [1:0] abv;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
      #1;
      check_eq("reset_out_valid", 64'({ov1, ov8, ov64}), 64'd0);
      check_eq("reset_y_w64", y64, 64'd0);
      check_eq("reset_y_op", 64'(yop8), 64'd0);
      check_eq("reset_ones_w8", 64'(yo8), 64'd0);
      check_eq("reset_in_ready", 64'({ir1, ir8, ir64}), 64'h7);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // All ops over all bit combinations; operands replicated so W=64 sees all-zero/all-one.
      for (int o = 0; o < 8; o++) begin
         for (int ab = 0; ab < 4; ab++) begin
            abv = 2'(ab);
            cycle(1'b1, 3'(o), {64{abv[1]}}, {64{abv[0]}}, 1'b1);
         end
      end
      drain();

      for (int i = 0; i < 16; i++) cycle(1'b1, 3'd4, 64'hF0, 64'h3C, 1'b1);
      drain();

      // Stall with input pressure, then release
      for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), 64'(i * 17 + 3), 64'(i * 5 + 9), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b1, 3'd1, 64'(i + 40), 64'h100, 1'b1);
      drain();

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) != 0);

      cycle(1'b1, 3'd5, 64'hA5, 64'h5A, 1'b0);
      cycle(1'b1, 3'd0, 64'hFF, 64'h0F, 1'b0);
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
      mid_reset();
      for (int i = 0; i < 60; i++)
         cycle($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      drain();

`ifdef GATE_UNIT_STATS_EN
      check_eq("beat_cnt", 64'(bc8), 64'(exp_beats));
      check_eq("stall_cnt", 64'(sc8), 64'(exp_stalls));
      @(negedge clk);
      force u_dut8.r_beat_cnt = 32'hFFFF_FFFF;
      #1;
      release u_dut8.r_beat_cnt;
      cycle(1'b1, 3'd7, 64'h12, 64'h0, 1'b1);
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
      cycle(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
      @(negedge clk);
      #1;
      check_eq("beat_cnt_wrap", 64'(bc8), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
